// File: rtl/led_matrix_col_scan.sv
// Time-multiplexed ROWS x COLS LED column scanner with refresh prescaler,
// per-column blanking and a per-frame snapshot of the spot inputs.
//   state   | meaning
//   S_IDLE  | display dark, waiting for en
//   S_BLANK | all rows/columns off for one tick before a column is lit
//   S_SHOW  | column r_col_idx lit with its snapshot rows for SHOW_TICKS ticks
module led_matrix_col_scan #(
  parameter int ROWS           = 4,
  parameter int COLS           = 2,
  parameter int DIV            = 4,
  parameter int SHOW_TICKS     = 3,
  parameter int ROW_ACTIVE_LOW = 1,
  parameter int COL_ACTIVE_LOW = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [ROWS*COLS-1:0] spot_in,
  output logic [ROWS-1:0]      row_out,
  output logic [COLS-1:0]      col_out,
  output logic                 frame_done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW = (SHOW_TICKS > 1) ? $clog2(SHOW_TICKS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [TW-1:0] T_LAST = TW'(SHOW_TICKS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);
  localparam logic ROW_INV = (ROW_ACTIVE_LOW != 0);
  localparam logic COL_INV = (COL_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  state_t                 r_state, w_state_nxt;
  logic [PW-1:0]          r_pcnt, w_pcnt_nxt;
  logic [TW-1:0]          r_tcnt, w_tcnt_nxt;
  logic [CW-1:0]          r_col_idx, w_col_idx_nxt;
  logic [ROWS*COLS-1:0]   r_snap, w_snap_nxt;
  logic                   r_frame_done, w_frame_done_nxt;
  logic                   w_tick;
  logic                   w_show;
  logic [ROWS-1:0]        w_rows_lit;
  logic [COLS-1:0]        w_col_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pcnt       <= '0;
      r_tcnt       <= '0;
      r_col_idx    <= '0;
      r_snap       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pcnt       <= w_pcnt_nxt;
      r_tcnt       <= w_tcnt_nxt;
      r_col_idx    <= w_col_idx_nxt;
      r_snap       <= w_snap_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign w_tick = (r_pcnt == P_LAST);

  always_comb begin
    w_state_nxt      = r_state;
    w_pcnt_nxt       = r_pcnt;
    w_tcnt_nxt       = r_tcnt;
    w_col_idx_nxt    = r_col_idx;
    w_snap_nxt       = r_snap;
    w_frame_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_state_nxt      = S_BLANK;
          w_snap_nxt       = spot_in;
          w_col_idx_nxt    = '0;
          w_pcnt_nxt       = '0;
          w_tcnt_nxt       = '0;
          w_frame_done_nxt = 1'b1;
        end
      end
      S_BLANK, S_SHOW: begin
        if (!en) begin
          // Dropping en beats any pending wrap, so no frame_done here.
          w_state_nxt   = S_IDLE;
          w_pcnt_nxt    = '0;
          w_tcnt_nxt    = '0;
          w_col_idx_nxt = '0;
        end else begin
          w_pcnt_nxt = w_tick ? '0 : r_pcnt + PW'(1);
          if (w_tick) begin
            if (r_state == S_BLANK) begin
              w_state_nxt = S_SHOW;
              w_tcnt_nxt  = '0;
            end else if (r_tcnt != T_LAST) begin
              w_tcnt_nxt = r_tcnt + TW'(1);
            end else begin
              w_state_nxt = S_BLANK;
              if (r_col_idx == C_LAST) begin
                w_col_idx_nxt    = '0;
                w_snap_nxt       = spot_in;
                w_frame_done_nxt = 1'b1;
              end else begin
                w_col_idx_nxt = r_col_idx + CW'(1);
              end
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode registered state only, so reset darkens them without a clock.
  assign w_show     = (r_state == S_SHOW);
  assign w_rows_lit = w_show ? r_snap[r_col_idx*ROWS +: ROWS] : '0;
  assign w_col_sel  = w_show ? (COLS'(1) << r_col_idx) : '0;
  assign row_out    = w_rows_lit ^ {ROWS{ROW_INV}};
  assign col_out    = w_col_sel ^ {COLS{COL_INV}};
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_led_matrix_col_scan.sv
// Bench for led_matrix_col_scan: default instance plus an 8x1, DIV=1 instance,
// both checked every clock against a frame-position reference model.
module tb_led_matrix_col_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_a, en_b;
  logic [7:0] spot_a, spot_b;
  logic [3:0] row_a;
  logic [1:0] col_a;
  logic       fd_a;
  logic [7:0] row_b;
  logic [0:0] col_b;
  logic       fd_b;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  led_matrix_col_scan dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .spot_in(spot_a),
    .row_out(row_a), .col_out(col_a), .frame_done(fd_a)
  );

  led_matrix_col_scan #(.ROWS(8), .COLS(1), .DIV(1), .SHOW_TICKS(1),
                        .ROW_ACTIVE_LOW(1), .COL_ACTIVE_LOW(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .spot_in(spot_b),
    .row_out(row_b), .col_out(col_b), .frame_done(fd_b)
  );

  // Model parameters per instance: rows, cols, div, show ticks, row/col active-low.
  int          p_rows[2] = '{4, 8};
  int          p_cols[2] = '{2, 1};
  int          p_div[2]  = '{4, 1};
  int          p_st[2]   = '{3, 1};
  int          p_rlow[2] = '{1, 1};
  int          p_clow[2] = '{0, 0};
  bit          m_act[2];
  int          m_p[2];
  logic [63:0] m_snap[2];

  // Invariant tracking on the default instance.
  bit prev_lit;
  int prev_col;
  int off_run;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 1'b0;
      m_p[k]   = 0;
      m_snap[k] = '0;
    end
  endtask

  task automatic model_edge(input int k, input logic en, input logic [63:0] spot);
    int frame;
    frame = p_cols[k] * (1 + p_st[k]) * p_div[k];
    if (!m_act[k]) begin
      if (en) begin
        m_act[k] = 1'b1; m_p[k] = 0; m_snap[k] = spot;
      end
    end else if (!en) begin
      m_act[k] = 1'b0; m_p[k] = 0;
    end else begin
      m_p[k]++;
      if (m_p[k] == frame) begin
        m_p[k] = 0; m_snap[k] = spot;
      end
    end
  endtask

  task automatic model_out(input int k, output logic [63:0] row, output logic [63:0] col,
                           output logic fd);
    int per, ci;
    bit lit;
    per = (1 + p_st[k]) * p_div[k];
    ci  = m_p[k] / per;
    lit = m_act[k] && ((m_p[k] % per) >= p_div[k]);
    fd  = m_act[k] && (m_p[k] == 0);
    row = '0;
    col = '0;
    for (int r = 0; r < p_rows[k]; r++) begin
      bit on;
      on = lit && m_snap[k][ci*p_rows[k] + r];
      row[r] = (p_rlow[k] != 0) ? !on : on;
    end
    for (int c = 0; c < p_cols[k]; c++) begin
      bit sel;
      sel = lit && (c == ci);
      col[c] = (p_clow[k] != 0) ? !sel : sel;
    end
  endtask

  task automatic check_outputs();
    logic [63:0] er, ec;
    logic        ef;
    model_out(0, er, ec, ef);
    chk("a_row", 64'(row_a), er);
    chk("a_col", 64'(col_a), ec);
    chk("a_fd",  64'(fd_a),  64'(ef));
    model_out(1, er, ec, ef);
    chk("b_row", 64'(row_b), er);
    chk("b_col", 64'(col_b), ec);
    chk("b_fd",  64'(fd_b),  64'(ef));
  endtask

  task automatic check_invariants();
    bit lit;
    int col;
    lit = (col_a != 2'b00);
    col = col_a[1] ? 1 : 0;
    chk("a_onehot", 64'($countones(col_a) > 1), 64'(0));
    if (lit && prev_lit)
      chk("a_switch_no_blank", 64'(col != prev_col), 64'(0));
    if (lit && !prev_lit)
      chk("a_blank_len_ok", 64'(off_run >= 4), 64'(1));
    off_run  = lit ? 0 : off_run + 1;
    prev_lit = lit;
    prev_col = col;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      model_edge(0, en_a, 64'(spot_a));
      model_edge(1, en_b, 64'(spot_b));
    end
    #1;
    check_outputs();
    check_invariants();
  endtask

  task automatic wait_pos(input string tag, input int target);
    int  budget;
    bit  hit;
    budget = 0;
    hit = 0;
    while (!hit && budget < 200) begin
      step();
      hit = m_act[0] && (m_p[0] == target);
      budget++;
    end
    chk(tag, 64'(hit), 64'(1));
  endtask

  initial begin
    rst_n  = 1'b0;
    en_a   = 1'b0;
    en_b   = 1'b0;
    spot_a = '0;
    spot_b = '0;
    prev_lit = 0;
    prev_col = 0;
    off_run  = 0;
    model_reset();
    #3;
    check_outputs();
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Directed frame: col0 rows 1001, col1 rows 0101; 8x1 instance alternates.
    spot_a = 8'b1010_0110;
    spot_b = 8'h81;
    en_a   = 1'b1;
    en_b   = 1'b1;
    step();
    chk("a_first_fd", 64'(fd_a), 64'(1));
    repeat (5) step();
    chk("a_col0_sel", 64'(col_a), 64'(2'b01));
    chk("a_col0_rows", 64'(row_a), 64'(4'b1001));
    chk("b_show_rows", 64'(row_b), 64'(8'h7E));
    repeat (70) step();

    // Mid-frame input change must wait for the next snapshot.
    wait_pos("wait_col0_show", 6);
    spot_a = 8'hFF;
    wait_pos("wait_next_col0_show", 6);
    chk("a_ff_rows", 64'(row_a), 64'(4'b0000));
    repeat (40) step();

    // Disable during column 1 show, then re-enable.
    wait_pos("wait_col1_show", 22);
    en_a = 1'b0;
    step();
    chk("a_dark_after_en0", 64'(col_a), 64'(2'b00));
    repeat (5) step();
    en_a = 1'b1;
    repeat (40) step();

    // Async reset mid-show: outputs off before any clock edge.
    wait_pos("wait_reset_point", 8);
    rst_n = 1'b0;
    #1;
    chk("rst_row", 64'(row_a), 64'(4'b1111));
    chk("rst_col", 64'(col_a), 64'(2'b00));
    chk("rst_fd",  64'(fd_a),  64'(0));
    model_reset();
    check_outputs();
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) step();

    // Random soak.
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 63) == 0) en_a = ~en_a;
      else if (!en_a && $urandom_range(0, 7) == 0) en_a = 1'b1;
      if ($urandom_range(0, 7) == 0) spot_a = 8'($urandom);
      en_b   = ($urandom_range(0, 19) != 0);
      spot_b = 8'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
